adder_result_checker: RTL and testbench

Response-side companion to the adder operand driver. It samples each operand pair the driver presents and delays the expected sum to match the adder's pipeline latency. It then compares the expected sum against the adder's res output and reports pass/fail counts plus details of the first mismatch. It sits beside adder_inst in the simulation top and lets a run self-check without waveform inspection.

---
 rtl/adder_result_checker.sv | 157 +++++++++++++++
 tb/tb_adder_result_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// adder_result_checker: samples operand pairs, delays (a+b) by the adder
// latency, and scores the adder's res_i against it, keeping pass/fail counts
// and the details of the first mismatch.
module adder_result_checker #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1,
    parameter int LENGTH  = 2000,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] res_i,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [CNT_W-1:0] first_fail_idx_o,
    output logic [WIDTH-1:0] first_fail_exp_o,
    output logic [WIDTH-1:0] first_fail_got_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  issue_q, issue_d;
    logic [CNT_W-1:0]                  pass_q, pass_d;
    logic [CNT_W-1:0]                  fail_q, fail_d;
    logic [CNT_W-1:0]                  ff_idx_q, ff_idx_d;
    logic [WIDTH-1:0]                  ff_exp_q, ff_exp_d;
    logic [WIDTH-1:0]                  ff_got_q, ff_got_d;
    logic                              error_q, error_d;
    // Delay line: each stage carries its own valid so gaps in vld_i survive.
    logic [LATENCY-1:0]                vld_pipe_q, vld_pipe_d;
    logic [LATENCY-1:0][WIDTH-1:0]     exp_pipe_q, exp_pipe_d;
    logic [LATENCY-1:0][CNT_W-1:0]     idx_pipe_q, idx_pipe_d;

    logic             push;
    logic             start_ok;
    logic [WIDTH-1:0] sum;

    // Next-state: delay-line shift, scoring of the emerging entry, run FSM.
    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        ff_idx_d   = ff_idx_q;
        ff_exp_d   = ff_exp_q;
        ff_got_d   = ff_got_q;
        error_d    = error_q;
        vld_pipe_d = vld_pipe_q;
        exp_pipe_d = exp_pipe_q;
        idx_pipe_d = idx_pipe_q;

        // Carry out is dropped by the WIDTH-bit sum.
        sum      = a_i + b_i;
        push     = (state_q == RUN) && vld_i && (issue_q != LEN_C);
        start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));

        vld_pipe_d[0] = push;
        exp_pipe_d[0] = sum;
        idx_pipe_d[0] = issue_q;
        for (int k = 1; k < LATENCY; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            exp_pipe_d[k] = exp_pipe_q[k-1];
            idx_pipe_d[k] = idx_pipe_q[k-1];
        end

        // Last stage lines up with res_i on this edge.
        if (vld_pipe_q[LATENCY-1]) begin
            if (res_i == exp_pipe_q[LATENCY-1]) begin
                if (pass_q != '1) pass_d = pass_q + ONE_C;
            end else begin
                if (fail_q != '1) fail_d = fail_q + ONE_C;
                error_d = 1'b1;
                if (!error_q) begin
                    ff_idx_d = idx_pipe_q[LATENCY-1];
                    ff_exp_d = exp_pipe_q[LATENCY-1];
                    ff_got_d = res_i;
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d    = RUN;
                    issue_d    = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    ff_idx_d   = '0;
                    ff_exp_d   = '0;
                    ff_got_d   = '0;
                    error_d    = 1'b0;
                    vld_pipe_d = '0;
                end
            end
            RUN: begin
                if (push) begin
                    issue_d = issue_q + ONE_C;
                    if (issue_q + ONE_C == LEN_C) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (vld_pipe_q == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; async active-low reset aborts any run in progress.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            issue_q    <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            ff_idx_q   <= '0;
            ff_exp_q   <= '0;
            ff_got_q   <= '0;
            error_q    <= 1'b0;
            vld_pipe_q <= '0;
            exp_pipe_q <= '0;
            idx_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            ff_idx_q   <= ff_idx_d;
            ff_exp_q   <= ff_exp_d;
            ff_got_q   <= ff_got_d;
            error_q    <= error_d;
            vld_pipe_q <= vld_pipe_d;
            exp_pipe_q <= exp_pipe_d;
            idx_pipe_q <= idx_pipe_d;
        end
    end

    assign pass_cnt_o       = pass_q;
    assign fail_cnt_o       = fail_q;
    assign first_fail_idx_o = ff_idx_q;
    assign first_fail_exp_o = ff_exp_q;
    assign first_fail_got_o = ff_got_q;
    assign error_o          = error_q;
    assign busy_o           = (state_q == RUN) || (state_q == DRAIN);
    assign done_o           = (state_q == DONE);

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench: two checkers (LATENCY=1 and LATENCY=3, LENGTH=4) beside small adder
// models with per-pair fault injection; run results are scoreboarded at done.
module tb_adder_result_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int pass; int fail; int err; int idx; int exp; int got;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    logic [7:0] PA[6] = '{8'd1, 8'd3, 8'd250, 8'd255, 8'd9, 8'd7};
    logic [7:0] PB[6] = '{8'd2, 8'd4, 8'd10,  8'd1,   8'd9, 8'd7};

    // DUT A: LATENCY=1
    logic        a_start, a_vld, a_bad, a_busy, a_done, a_err;
    logic [7:0]  a_a, a_b, a_res, a_bval, a_fexp, a_fgot;
    logic [15:0] a_pass, a_fail, a_fidx;

    // DUT B: LATENCY=3
    logic        b_start, b_vld, b_bad, b_busy, b_done, b_err;
    logic [7:0]  b_a, b_b, b_res, b_bval, b_fexp, b_fgot, b_r1, b_r2;
    logic [15:0] b_pass, b_fail, b_fidx;

    adder_result_checker #(.WIDTH(8), .LATENCY(1), .LENGTH(4), .CNT_W(16)) u_a (
        .clk_i(clk), .reset_i(rst_n), .start_i(a_start), .vld_i(a_vld),
        .a_i(a_a), .b_i(a_b), .res_i(a_res),
        .pass_cnt_o(a_pass), .fail_cnt_o(a_fail), .first_fail_idx_o(a_fidx),
        .first_fail_exp_o(a_fexp), .first_fail_got_o(a_fgot),
        .busy_o(a_busy), .done_o(a_done), .error_o(a_err));

    adder_result_checker #(.WIDTH(8), .LATENCY(3), .LENGTH(4), .CNT_W(16)) u_b (
        .clk_i(clk), .reset_i(rst_n), .start_i(b_start), .vld_i(b_vld),
        .a_i(b_a), .b_i(b_b), .res_i(b_res),
        .pass_cnt_o(b_pass), .fail_cnt_o(b_fail), .first_fail_idx_o(b_fidx),
        .first_fail_exp_o(b_fexp), .first_fail_got_o(b_fgot),
        .busy_o(b_busy), .done_o(b_done), .error_o(b_err));

    // Adder models; a flagged pair returns the injected value instead of the sum.
    always @(posedge clk) begin
        a_res <= a_bad ? a_bval : 8'(a_a + a_b);
        b_r1  <= b_bad ? b_bval : 8'(b_a + b_b);
        b_r2  <= b_r1;
        b_res <= b_r2;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int p, input int f, input int e,
                                input int i, input int x, input int g);
        exp_t r;
        r.pass = p; r.fail = f; r.err = e; r.idx = i; r.exp = x; r.got = g;
        return r;
    endfunction

    // Monitor A: score the run on each rising done_o.
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (a_done && !prev) begin
                if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_pass", a_pass, e.pass);
                    chk("a_fail", a_fail, e.fail);
                    chk("a_error", a_err, e.err);
                    chk("a_ff_idx", a_fidx, e.idx);
                    chk("a_ff_exp", a_fexp, e.exp);
                    chk("a_ff_got", a_fgot, e.got);
                    chk("a_busy_at_done", a_busy, 0);
                end
            end
            prev = a_done;
        end
    end

    // Monitor B: score the run on each rising done_o.
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (b_done && !prev) begin
                if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_pass", b_pass, e.pass);
                    chk("b_fail", b_fail, e.fail);
                    chk("b_error", b_err, e.err);
                    chk("b_ff_idx", b_fidx, e.idx);
                    chk("b_ff_exp", b_fexp, e.exp);
                    chk("b_ff_got", b_fgot, e.got);
                    chk("b_busy_at_done", b_busy, 0);
                end
            end
            prev = b_done;
        end
    end

    // One run on DUT A: n pairs back to back, optional start pulse in DRAIN,
    // then a bounded wait for done with the expected number of extra cycles.
    task automatic run_a(input int n, input logic [5:0] bad, input logic [7:0] bv,
                         input bit drain_start, input int exp_w);
        int w;
        a_start = 1'b1; step(); a_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            a_a = PA[i]; a_b = PB[i]; a_bad = bad[i]; a_bval = bv; a_vld = 1'b1;
            step();
        end
        a_vld = 1'b0; a_bad = 1'b0;
        w = 0;
        if (drain_start) begin
            a_start = 1'b1; step(); a_start = 1'b0; w = 1;
        end
        while (!a_done && w < 10) begin step(); w++; end
        chk("a_done_wait", w, exp_w);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_pass"}, a_pass, 0);
        chk({tag, "_fail"}, a_fail, 0);
        chk({tag, "_ffexp"}, a_fexp, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_done"}, a_done, 0);
        chk({tag, "_error"}, a_err, 0);
    endtask

    initial begin
        int w;
        a_start = 0; a_vld = 0; a_bad = 0; a_a = 0; a_b = 0; a_bval = 0;
        b_start = 0; b_vld = 0; b_bad = 0; b_a = 0; b_b = 0; b_bval = 0;
        repeat (2) step();
        chk_zero_a("rst_a");
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_done", b_done, 0);
        chk("rst_b_fidx", b_fidx, 0);
        rst_n = 1'b1;
        step();

        // Clean run, LATENCY=1
        qa.push_back(mk(4, 0, 0, 0, 0, 0));
        run_a(4, 6'b000000, 8'h00, 0, 2);

        // Pair 2 (250+10 -> 8'h04) returned as 8'h00
        qa.push_back(mk(3, 1, 1, 2, 8'h04, 8'h00));
        run_a(4, 6'b000100, 8'h00, 0, 2);

        // LATENCY=3 with gaps, faults at 1 (exp 7) and 3 (exp 0)
        qb.push_back(mk(2, 2, 1, 1, 8'h07, 8'hAA));
        b_start = 1'b1; step(); b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_a = PA[i]; b_b = PB[i]; b_bad = (i == 1 || i == 3); b_bval = 8'hAA;
            b_vld = 1'b1; step();
            b_vld = 1'b0; b_bad = 1'b0; step();
        end
        w = 0;
        while (!b_done && w < 10) begin step(); w++; end
        chk("b_done_wait", w, 3);

        // Six pulses into a 4-pair run; the done edge lands with pulse 6
        qa.push_back(mk(4, 0, 0, 0, 0, 0));
        run_a(6, 6'b000000, 8'h00, 0, 0);

        // Reset mid-run after 2 pairs (pair 0 faulted so state is nonzero)
        a_start = 1'b1; step(); a_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_a = PA[i]; a_b = PB[i]; a_bad = (i == 0); a_bval = 8'h00; a_vld = 1'b1;
            step();
        end
        a_vld = 1'b0; a_bad = 1'b0;
        chk("mid_fail_pre", a_fail, 1);
        chk("mid_busy_pre", a_busy, 1);
        chk("mid_ffexp_pre", a_fexp, 3);
        rst_n = 1'b0;
        #1;
        chk_zero_a("mid_rst");
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_idle", a_busy, 0);
        qa.push_back(mk(4, 0, 0, 0, 0, 0));
        run_a(4, 6'b000000, 8'h00, 0, 2);

        // Start during DRAIN is ignored; done holds; rerun matches
        qa.push_back(mk(4, 0, 0, 0, 0, 0));
        run_a(4, 6'b000000, 8'h00, 1, 2);
        repeat (3) step();
        chk("done_hold", a_done, 1);
        chk("done_hold_pass", a_pass, 4);
        qa.push_back(mk(4, 0, 0, 0, 0, 0));
        run_a(4, 6'b000000, 8'h00, 0, 2);

        repeat (3) step();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
